// File: rtl/inst_buffer.sv
// Instruction buffer between predecode and decode: a circular queue that accepts up to
// IN_WIDTH slots per cycle and delivers up to OUT_WIDTH oldest slots per cycle.
module inst_buffer #(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4,
    parameter int FSQ_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [IN_WIDTH-1:0]             in_en,
    input  logic [$clog2(IN_WIDTH):0]       in_num,
    input  logic [IN_WIDTH*32-1:0]          in_inst,
    input  logic [FSQ_WIDTH-1:0]            in_fsqIdx,
    output logic                            full,
    input  logic                            backend_stall,
    output logic [OUT_WIDTH-1:0]            out_valid,
    output logic [OUT_WIDTH*32-1:0]         out_inst,
    output logic [OUT_WIDTH*FSQ_WIDTH-1:0]  out_fsqIdx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(IN_WIDTH) + 1;

    logic [AW-1:0]        head_q, head_d;
    logic [AW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        enq_num, deq_num;
    logic                 accept;

    logic [31:0]          inst_mem [DEPTH];
    logic [FSQ_WIDTH-1:0] fsq_mem  [DEPTH];

    always_comb begin
        full    = (count_q > CW'(DEPTH - IN_WIDTH));
        accept  = (|in_en) && !full && !flush;
        enq_num = accept ? CW'(in_num) : '0;
        deq_num = '0;
        if (!backend_stall && !flush) begin
            deq_num = (count_q < CW'(OUT_WIDTH)) ? count_q : CW'(OUT_WIDTH);
        end
        head_d  = head_q + deq_num[AW-1:0];
        tail_d  = tail_q + enq_num[AW-1:0];
        count_d = count_q + enq_num - deq_num;
        // A redirect drops both the incoming group and this cycle's dequeue.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; pointer arithmetic wraps naturally at AW bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (NW'(i) < in_num) begin
                    inst_mem[tail_q + AW'(i)] <= in_inst[i*32 +: 32];
                    fsq_mem[tail_q + AW'(i)]  <= in_fsqIdx;
                end
            end
        end
    end

    always_comb begin
        out_valid  = '0;
        out_inst   = '0;
        out_fsqIdx = '0;
        for (int j = 0; j < OUT_WIDTH; j++) begin
            out_valid[j]                        = (CW'(j) < count_q) && !flush;
            out_inst[j*32 +: 32]                = inst_mem[head_q + AW'(j)];
            out_fsqIdx[j*FSQ_WIDTH +: FSQ_WIDTH] = fsq_mem[head_q + AW'(j)];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (count_q <= CW'(DEPTH)) && ((int'(count_q) + int'(enq_num)) <= DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        deq_num <= count_q);
    a_in_num_legal: assert property (@(posedge clk) disable iff (!rst)
        (|in_en) |-> (in_num == NW'($countones(in_en))));

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: accepted slots are queued as {fsqIdx, inst} and
// popped in order as they appear on the output slots.
module tb_inst_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [7:0]   in_en = '0;
    logic [3:0]   in_num = '0;
    logic [255:0] in_inst = '0;
    logic [7:0]   in_fsqIdx = '0;
    logic         full;
    logic         backend_stall = 1'b0;
    logic [3:0]   out_valid;
    logic [127:0] out_inst;
    logic [31:0]  out_fsqIdx;

    int total = 0;
    int bad = 0;
    logic [39:0] sb [$];

    inst_buffer #(.DEPTH(16), .IN_WIDTH(8), .OUT_WIDTH(4), .FSQ_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_en(in_en), .in_num(in_num),
        .in_inst(in_inst), .in_fsqIdx(in_fsqIdx), .full(full),
        .backend_stall(backend_stall), .out_valid(out_valid),
        .out_inst(out_inst), .out_fsqIdx(out_fsqIdx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic [31:0] base, input logic [7:0] fsq);
        in_en   = '0;
        in_inst = '0;
        for (int i = 0; i < n; i++) begin
            in_en[i]            = 1'b1;
            in_inst[i*32 +: 32] = base + 32'(i);
        end
        in_num    = 4'(n);
        in_fsqIdx = fsq;
    endtask

    task automatic push_grp(input int n, input logic [31:0] base, input logic [7:0] fsq);
        for (int i = 0; i < n; i++) sb.push_back({fsq, base + 32'(i)});
    endtask

    task automatic idle;
        in_en  = '0;
        in_num = '0;
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (out_valid !== 4'b0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got valid=%b full=%b exp valid=0000 full=0", out_valid, full);
        end
        tick;
        rst = 1'b1;
        tick;
        total++;
        if (out_valid !== 4'b0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got valid=%b full=%b exp valid=0000 full=0", out_valid, full);
        end
    endtask

    task automatic test_basic;
        logic [39:0] e;
        backend_stall = 1'b0;
        drive(8, 32'h100, 8'd3);
        push_grp(8, 32'h100, 8'd3);
        #1;
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL basic_no_bypass got valid=%b exp=0000", out_valid);
        end
        tick;
        idle;
        #1;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (out_valid !== 4'b1111) begin
                bad++;
                $display("FAIL basic_valid cyc%0d got=%b exp=1111", c, out_valid);
            end
            for (int j = 0; j < 4; j++) begin
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                total++;
                if (out_inst[j*32 +: 32] !== e[31:0] || out_fsqIdx[j*8 +: 8] !== e[39:32]) begin
                    bad++;
                    $display("FAIL basic_slot cyc%0d slot%0d got inst=%h fsq=%h exp inst=%h fsq=%h",
                             c, j, out_inst[j*32 +: 32], out_fsqIdx[j*8 +: 8], e[31:0], e[39:32]);
                end
            end
            tick;
        end
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL basic_empty got valid=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_full;
        logic [39:0] e;
        backend_stall = 1'b1;
        drive(8, 32'h200, 8'd1);
        push_grp(8, 32'h200, 8'd1);
        tick;
        total++;
        if (full !== 1'b0) begin
            bad++;
            $display("FAIL full_at8 got full=%b exp=0", full);
        end
        drive(8, 32'h210, 8'd2);
        push_grp(8, 32'h210, 8'd2);
        tick;
        total++;
        if (full !== 1'b1 || out_valid !== 4'b1111) begin
            bad++;
            $display("FAIL full_at16 got full=%b valid=%b exp full=1 valid=1111", full, out_valid);
        end
        drive(8, 32'h300, 8'd9);
        tick;
        total++;
        if (full !== 1'b1 || out_inst[31:0] !== 32'h200) begin
            bad++;
            $display("FAIL full_ignore got full=%b slot0=%h exp full=1 slot0=200", full, out_inst[31:0]);
        end
        idle;
        backend_stall = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (out_valid !== 4'b1111 || full !== (sb.size() > 8)) begin
                bad++;
                $display("FAIL full_drain cyc%0d got valid=%b full=%b exp valid=1111 full=%b",
                         c, out_valid, full, sb.size() > 8);
            end
            for (int j = 0; j < 4; j++) begin
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                total++;
                if (out_inst[j*32 +: 32] !== e[31:0] || out_fsqIdx[j*8 +: 8] !== e[39:32]) begin
                    bad++;
                    $display("FAIL full_slot cyc%0d slot%0d got inst=%h fsq=%h exp inst=%h fsq=%h",
                             c, j, out_inst[j*32 +: 32], out_fsqIdx[j*8 +: 8], e[31:0], e[39:32]);
                end
            end
            tick;
        end
        total++;
        if (out_valid !== 4'b0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL full_empty got valid=%b full=%b exp valid=0000 full=0", out_valid, full);
        end
    endtask

    task automatic test_wrap;
        logic [39:0] e;
        int n;
        // Pointers sit at 8 after the previous tests; six more move tail to 14.
        backend_stall = 1'b1;
        drive(6, 32'h400, 8'd4);
        push_grp(6, 32'h400, 8'd4);
        tick;
        drive(5, 32'h500, 8'd5);
        push_grp(5, 32'h500, 8'd5);
        tick;
        idle;
        backend_stall = 1'b0;
        #1;
        for (int c = 0; c < 6 && sb.size() > 0; c++) begin
            n = (sb.size() > 4) ? 4 : sb.size();
            total++;
            if (out_valid !== 4'((1 << n) - 1)) begin
                bad++;
                $display("FAIL wrap_valid cyc%0d got=%b exp=%b", c, out_valid, 4'((1 << n) - 1));
            end
            for (int j = 0; j < n; j++) begin
                e = sb.pop_front();
                total++;
                if (out_inst[j*32 +: 32] !== e[31:0] || out_fsqIdx[j*8 +: 8] !== e[39:32]) begin
                    bad++;
                    $display("FAIL wrap_slot cyc%0d slot%0d got inst=%h fsq=%h exp inst=%h fsq=%h",
                             c, j, out_inst[j*32 +: 32], out_fsqIdx[j*8 +: 8], e[31:0], e[39:32]);
                end
            end
            tick;
        end
        total++;
        if (out_valid !== 4'b0000 || sb.size() != 0) begin
            bad++;
            $display("FAIL wrap_empty got valid=%b left=%0d exp valid=0000 left=0", out_valid, sb.size());
        end
    endtask

    task automatic test_simultaneous;
        logic [39:0] e;
        logic [3:0]  m;
        backend_stall = 1'b1;
        drive(6, 32'h600, 8'd6);
        push_grp(6, 32'h600, 8'd6);
        tick;
        backend_stall = 1'b0;
        drive(3, 32'h700, 8'd7);
        push_grp(3, 32'h700, 8'd7);
        #1;
        for (int c = 0; c < 3; c++) begin
            m = (c == 2) ? 4'b0001 : 4'b1111;
            total++;
            if (out_valid !== m) begin
                bad++;
                $display("FAIL simul_valid cyc%0d got=%b exp=%b", c, out_valid, m);
            end
            for (int j = 0; j < 4; j++) begin
                if (m[j]) begin
                    e = (sb.size() > 0) ? sb.pop_front() : '1;
                    total++;
                    if (out_inst[j*32 +: 32] !== e[31:0] || out_fsqIdx[j*8 +: 8] !== e[39:32]) begin
                        bad++;
                        $display("FAIL simul_slot cyc%0d slot%0d got inst=%h fsq=%h exp inst=%h fsq=%h",
                                 c, j, out_inst[j*32 +: 32], out_fsqIdx[j*8 +: 8], e[31:0], e[39:32]);
                    end
                end
            end
            tick;
            idle;
            #1;
        end
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL simul_empty got valid=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_flush;
        logic [39:0] e;
        backend_stall = 1'b1;
        drive(8, 32'h800, 8'd8);
        tick;
        drive(2, 32'h808, 8'd8);
        tick;
        drive(8, 32'h880, 8'd8);
        flush = 1'b1;
        #1;
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL flush_comb got valid=%b exp=0000", out_valid);
        end
        tick;
        flush = 1'b0;
        idle;
        #1;
        total++;
        if (out_valid !== 4'b0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL flush_after got valid=%b full=%b exp valid=0000 full=0", out_valid, full);
        end
        backend_stall = 1'b0;
        drive(4, 32'h900, 8'd7);
        push_grp(4, 32'h900, 8'd7);
        tick;
        idle;
        #1;
        total++;
        if (out_valid !== 4'b1111) begin
            bad++;
            $display("FAIL flush_new_valid got=%b exp=1111", out_valid);
        end
        for (int j = 0; j < 4; j++) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++;
            if (out_inst[j*32 +: 32] !== e[31:0] || out_fsqIdx[j*8 +: 8] !== e[39:32]) begin
                bad++;
                $display("FAIL flush_new_slot slot%0d got inst=%h fsq=%h exp inst=%h fsq=%h",
                         j, out_inst[j*32 +: 32], out_fsqIdx[j*8 +: 8], e[31:0], e[39:32]);
            end
        end
        tick;
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL flush_new_empty got valid=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [39:0] e;
        backend_stall = 1'b1;
        drive(8, 32'hA00, 8'd10);
        tick;
        drive(4, 32'hA08, 8'd10);
        tick;
        idle;
        #1;
        total++;
        if (full !== 1'b1 || out_valid !== 4'b1111) begin
            bad++;
            $display("FAIL rstmid_pre got full=%b valid=%b exp full=1 valid=1111", full, out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got valid=%b full=%b exp valid=0000 full=0", out_valid, full);
        end
        tick;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 4'b0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after got valid=%b full=%b exp valid=0000 full=0", out_valid, full);
        end
        backend_stall = 1'b0;
        drive(2, 32'hB00, 8'd11);
        push_grp(2, 32'hB00, 8'd11);
        tick;
        idle;
        #1;
        total++;
        if (out_valid !== 4'b0011) begin
            bad++;
            $display("FAIL rstmid_new_valid got=%b exp=0011", out_valid);
        end
        for (int j = 0; j < 2; j++) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            total++;
            if (out_inst[j*32 +: 32] !== e[31:0] || out_fsqIdx[j*8 +: 8] !== e[39:32]) begin
                bad++;
                $display("FAIL rstmid_new_slot slot%0d got inst=%h fsq=%h exp inst=%h fsq=%h",
                         j, out_inst[j*32 +: 32], out_fsqIdx[j*8 +: 8], e[31:0], e[39:32]);
            end
        end
        tick;
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL rstmid_new_empty got valid=%b exp=0000", out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_wrap;
        test_simultaneous;
        test_flush;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
